// File: rtl/spirose_pkg.sv
// Shared types and slice-count defaults for the rotating display.
// The framebuffer addressing uses the same slice-count defaults.
package spirose_pkg;
    localparam int NB_SLICES  = 128;
    localparam int SLICE_LOG2 = 7;

    typedef enum logic [1:0] {IDLE, MEASURE, RUN, STALLED} slice_state_t;
endpackage

// File: rtl/hall_sync.sv
// Hall sensor front end: synchroniser, falling-edge detect, debounce window.
// Owns the free-running rotation period counter.
module hall_sync #(
    parameter int PERIOD_WIDTH = 24,
    parameter int MIN_PERIOD   = 4096,
    parameter int MAX_PERIOD   = 2**24-2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hall_n,
    input  logic                    accept_any,
    output logic                    hall_evt_accepted,
    output logic [PERIOD_WIDTH-1:0] period_cnt
);
    localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] MAX_P = PERIOD_WIDTH'(MAX_PERIOD);

    logic sync1, sync2, sync2_d, hall_evt;

    // Idle level of the sensor is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync2_d  <= 1'b1;
            hall_evt <= 1'b0;
        end else begin
            sync1    <= hall_n;
            sync2    <= sync1;
            sync2_d  <= sync2;
            hall_evt <= sync2_d & ~sync2;
        end
    end

    assign hall_evt_accepted = hall_evt & (accept_any | (period_cnt >= MIN_P));

    // Saturates at MAX_PERIOD+1 so the stall condition stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            period_cnt <= '0;
        else if (hall_evt_accepted)
            period_cnt <= '0;
        else if (period_cnt <= MAX_P)
            period_cnt <= period_cnt + 1'b1;
    end
endmodule

// File: rtl/slice_scheduler.sv
// Divides the measured rotor period into NB_SLICES slices and issues one
// clk_enable-qualified position_sync strobe per slice.
module slice_scheduler #(
    parameter int NB_SLICES    = spirose_pkg::NB_SLICES,
    parameter int SLICE_LOG2   = spirose_pkg::SLICE_LOG2,
    parameter int PERIOD_WIDTH = 24,
    parameter int MIN_PERIOD   = 4096,
    parameter int MAX_PERIOD   = 2**24-2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_enable,
    input  logic                    hall_n,
    output logic                    position_sync,
    output logic [SLICE_LOG2-1:0]   slice_idx,
    output logic                    rotation_valid,
    output logic [PERIOD_WIDTH-1:0] period
);
    import spirose_pkg::*;

    localparam int LEN_W = PERIOD_WIDTH - SLICE_LOG2;
    localparam logic [PERIOD_WIDTH-1:0] MAX_P = PERIOD_WIDTH'(MAX_PERIOD);
    localparam logic [SLICE_LOG2-1:0]   LAST  = SLICE_LOG2'(NB_SLICES - 1);

    slice_state_t            state_q, state_d;
    logic [PERIOD_WIDTH-1:0] period_cnt, period_q, period_next;
    logic [LEN_W-1:0]        slice_len_q, slice_cnt_q;
    logic [SLICE_LOG2-1:0]   idx_q;
    logic                    pending_q;
    logic                    evt_acc, stalled, last_slice, slice_end;
    logic                    latch, step, enter_stall, req;

    hall_sync #(
        .PERIOD_WIDTH (PERIOD_WIDTH),
        .MIN_PERIOD   (MIN_PERIOD),
        .MAX_PERIOD   (MAX_PERIOD)
    ) u_hall_sync (
        .clk               (clk),
        .rst               (rst),
        .hall_n            (hall_n),
        .accept_any        ((state_q == IDLE) || (state_q == STALLED)),
        .hall_evt_accepted (evt_acc),
        .period_cnt        (period_cnt)
    );

    assign stalled     = period_cnt > MAX_P;
    assign last_slice  = idx_q == LAST;
    assign slice_end   = slice_cnt_q == slice_len_q - 1'b1;
    // The counter clears on the hall cycle itself, so that cycle is added back.
    assign period_next = period_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        latch       = 1'b0;
        step        = 1'b0;
        enter_stall = 1'b0;
        case (state_q)
            IDLE, STALLED: if (evt_acc) state_d = MEASURE;
            MEASURE: begin
                if (stalled) begin
                    state_d     = STALLED;
                    enter_stall = 1'b1;
                end else if (evt_acc) begin
                    state_d = RUN;
                    latch   = 1'b1;
                end
            end
            RUN: begin
                if (stalled) begin
                    state_d     = STALLED;
                    enter_stall = 1'b1;
                end else if (evt_acc) begin
                    latch = 1'b1;
                end else if (slice_end && !last_slice) begin
                    step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req = latch | step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q    <= '0;
            slice_len_q <= '0;
            slice_cnt_q <= '0;
            idx_q       <= '0;
        end else if (latch) begin
            period_q    <= period_next;
            slice_len_q <= period_next[PERIOD_WIDTH-1:SLICE_LOG2];
            slice_cnt_q <= '0;
            idx_q       <= '0;
        end else if (enter_stall) begin
            idx_q <= '0;
        end else if (step) begin
            idx_q       <= idx_q + 1'b1;
            slice_cnt_q <= '0;
        end else if (state_q == RUN && !last_slice) begin
            slice_cnt_q <= slice_cnt_q + 1'b1;
        end
    end

    // Requests are registered first; a later request merges into an unserved one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              pending_q <= 1'b0;
        else if (enter_stall) pending_q <= 1'b0;
        else if (req)         pending_q <= 1'b1;
        else if (clk_enable)  pending_q <= 1'b0;
    end

    assign position_sync  = pending_q & clk_enable;
    assign slice_idx      = idx_q;
    assign rotation_valid = state_q == RUN;
    assign period         = period_q;
endmodule

// File: tb/tb_slice_scheduler.sv
// Directed bench for slice_scheduler: cycle-level model of rotation timing
// plus hand-computed checkpoints per scenario.
module tb_slice_scheduler;
    localparam int NS   = 128;
    localparam int MINP = 4096;
    localparam int MAXP = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b1;
    logic        hall_n = 1'b1;
    logic        position_sync;
    logic [6:0]  slice_idx;
    logic        rotation_valid;
    logic [23:0] period;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_mode = 0;
    int nstrobe = 0, noen = 0, dur127 = 0;

    slice_scheduler #(
        .NB_SLICES(NS), .SLICE_LOG2(7), .PERIOD_WIDTH(24),
        .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)
    ) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .hall_n(hall_n),
        .position_sync(position_sync), .slice_idx(slice_idx),
        .rotation_valid(rotation_valid), .period(period)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1 clk_enable = (en_mode == 0) || (cyc % 3 == 0);
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (position_sync) nstrobe++;
            if (position_sync && !clk_enable) noen++;
            if (slice_idx == 7'd127) dur127++;
        end
    end

    // Model: states 0 idle, 1 measuring, 2 running, 3 stalled. A hall fall seen
    // at cycle c takes effect at edge c+4; slice k of a run starts k*len cycles
    // after the accepted edge, len = period/NS, last slice held until next edge.
    int m_state = 0, m_last = 0, m_len = 1, m_per = 0;
    bit m_owed = 0, m_prev_hall = 1;
    int m_q[$];
    initial forever begin
        int el, exp_idx;
        bit evt, acc, req;
        @(negedge clk);
        if (rst) begin
            m_state = 0; m_last = 0; m_len = 1; m_per = 0; m_owed = 0;
            m_q.delete();
            m_prev_hall = hall_n;
        end else begin
            if (m_prev_hall && !hall_n) m_q.push_back(cyc + 4);
            m_prev_hall = hall_n;
            evt = 0;
            if (m_q.size() > 0 && m_q[0] == cyc) begin
                evt = 1;
                void'(m_q.pop_front());
            end
            req = 0;
            el  = cyc - m_last;
            acc = evt && (m_state == 0 || m_state == 3 || el > MINP);
            if ((m_state == 1 || m_state == 2) && el - 1 > MAXP) begin
                m_state = 3;
                m_owed  = 0;
                if (acc) m_last = cyc;
            end else if (acc) begin
                if (m_state == 1 || m_state == 2) begin
                    m_per = el; m_len = el / NS; m_state = 2; req = 1;
                end else begin
                    m_state = 1;
                end
                m_last = cyc;
            end else if (m_state == 2) begin
                if (el % m_len == 0 && el / m_len >= 1 && el / m_len < NS) req = 1;
            end
            if (req) m_owed = 1;
            exp_idx = 0;
            if (m_state == 2) begin
                exp_idx = (cyc - m_last) / m_len;
                if (exp_idx > NS - 1) exp_idx = NS - 1;
            end
            chk("model_sync", int'(position_sync), int'(m_owed && clk_enable));
            chk("model_idx", int'(slice_idx), exp_idx);
            chk("model_valid", int'(rotation_valid), int'(m_state == 2));
            chk("model_period", int'(period), m_per);
            if (clk_enable) m_owed = 0;
        end
    end

    // Called #1 after a posedge; returns #1 after the posedge n cycles later.
    task automatic pulse_turn(input int n);
        hall_n = 1'b0;
        repeat (20) @(posedge clk);
        #1 hall_n = 1'b1;
        repeat (n - 20) @(posedge clk);
        #1;
    endtask

    initial begin
        int s0, v0, d0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sync", int'(position_sync), 0);
        chk("reset_idx", int'(slice_idx), 0);
        chk("reset_valid", int'(rotation_valid), 0);
        chk("reset_period", int'(period), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        s0 = nstrobe;
        pulse_turn(12800);
        chk("measure_strobes", nstrobe - s0, 0);
        chk("measure_valid", int'(rotation_valid), 0);

        s0 = nstrobe;
        pulse_turn(12800);
        chk("run_strobes", nstrobe - s0, 128);
        chk("run_period", int'(period), 12800);
        chk("run_valid", int'(rotation_valid), 1);

        en_mode = 1;
        s0 = nstrobe; v0 = noen; d0 = dur127;
        pulse_turn(12900);
        en_mode = 0;
        chk("gated_strobes", nstrobe - s0, 128);
        chk("gated_unqualified", noen - v0, 0);
        chk("last_slice_len", dur127 - d0, 200);

        s0 = nstrobe;
        hall_n = 1'b0;
        repeat (20) @(posedge clk);
        #1 hall_n = 1'b1;
        repeat (30) @(posedge clk);
        #1 hall_n = 1'b0;
        repeat (10) @(posedge clk);
        #1 hall_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_period", int'(period), 12900);
        chk("glitch_idx0", int'(slice_idx), 0);
        repeat (400) @(posedge clk);
        #1;
        chk("glitch_idx4", int'(slice_idx), 4);
        repeat (8550) @(posedge clk);
        #1;
        chk("speedup_idx90", int'(slice_idx), 90);
        chk("speedup_strobes", nstrobe - s0, 91);

        s0 = nstrobe;
        hall_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("speedup_jump_idx", int'(slice_idx), 0);
        chk("speedup_period", int'(period), 9050);
        repeat (10) @(posedge clk);
        #1 hall_n = 1'b1;
        repeat (344) @(posedge clk);
        #1;
        chk("speedup_len70_idx", int'(slice_idx), 5);
        repeat (20100 - 364) @(posedge clk);
        #1;
        chk("stall_valid", int'(rotation_valid), 0);
        chk("stall_idx", int'(slice_idx), 0);
        chk("stall_strobes", nstrobe - s0, 128);

        s0 = nstrobe;
        pulse_turn(12800);
        chk("restart_measure_strobes", nstrobe - s0, 0);
        chk("restart_measure_valid", int'(rotation_valid), 0);

        pulse_turn(3000);
        chk("restart_run_valid", int'(rotation_valid), 1);
        chk("restart_run_period", int'(period), 12800);
        chk("restart_run_idx", int'(slice_idx), 29);

        #1 rst = 1'b1;
        #1;
        chk("midrun_rst_sync", int'(position_sync), 0);
        chk("midrun_rst_idx", int'(slice_idx), 0);
        chk("midrun_rst_valid", int'(rotation_valid), 0);
        chk("midrun_rst_period", int'(period), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_valid", int'(rotation_valid), 0);
        chk("post_rst_sync_count", int'(position_sync), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
